gemm_tile_controller: RTL and testbench

Parametrised next-generation loop controller for the GeMM accelerator. It sequences the M/K/N block loops with a runtime-selectable outer loop order and valid/ready handshakes on operand issue and result write-back. It models the MAC pipeline latency and buffers completed C-block descriptors, applying backpressure so no result is dropped. It sits between the operand SRAM address generators and the C write-back path in the accelerator top.

---
 rtl/gemm_ctrl_pkg.sv | 25 ++
 rtl/gemm_result_fifo.sv | 40 ++++
 rtl/gemm_tile_controller.sv | 125 ++++++++++++
 tb/tb_gemm_tile_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gemm_ctrl_pkg.sv
// gemm_ctrl_pkg: shared types and helpers for the GeMM tile loop controller.
package gemm_ctrl_pkg;
    localparam int AddrWidth = 16;

    typedef enum logic {
        ORDER_MNK = 1'b0,
        ORDER_NMK = 1'b1
    } loop_order_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic [AddrWidth-1:0] m;
        logic [AddrWidth-1:0] n;
    } result_desc_t;

    function automatic int outstanding_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/gemm_result_fifo.sv
// gemm_result_fifo: FIFO of completed C-block descriptors; head reads as zero when empty.
module gemm_result_fifo
    import gemm_ctrl_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  result_desc_t wdata,
    input  logic         pop,
    output logic         valid,
    output result_desc_t rdata
);
    localparam int PW = Depth > 1 ? $clog2(Depth) : 1;

    result_desc_t   mem [Depth];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;

    assign valid = count != '0;
    assign rdata = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(Depth - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop) rd_ptr <= (rd_ptr == PW'(Depth - 1)) ? '0 : rd_ptr + PW'(1);
            count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/gemm_tile_controller.sv
// gemm_tile_controller: M/K/N block loop sequencer with selectable outer order,
// MAC latency model and backpressured result descriptor buffer.
module gemm_tile_controller
    import gemm_ctrl_pkg::*;
#(
    parameter int PipeLatency = 2,
    parameter int OutDepth    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 loop_order_i,
    input  logic [AddrWidth-1:0] M_size_i,
    input  logic [AddrWidth-1:0] K_size_i,
    input  logic [AddrWidth-1:0] N_size_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [AddrWidth-1:0] M_count_o,
    output logic [AddrWidth-1:0] K_count_o,
    output logic [AddrWidth-1:0] N_count_o,
    output logic                 init_save_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [AddrWidth-1:0] out_m_o,
    output logic [AddrWidth-1:0] out_n_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);
    localparam int OW = outstanding_width(OutDepth);

    ctrl_state_e          state;
    loop_order_e          order;
    logic [AddrWidth-1:0] m_size, k_size, n_size;
    logic [AddrWidth-1:0] m_cnt, k_cnt, n_cnt;
    logic [OW-1:0]        outstanding, out_nxt;
    logic                 err;
    logic [PipeLatency:0] pipe_v;
    result_desc_t         pipe_d [PipeLatency+1];
    result_desc_t         head;
    logic k_last, m_last, n_last, m_tick, n_tick, fire, push, pop, size_ok;

    assign k_last      = k_cnt == k_size - AddrWidth'(1);
    assign m_last      = m_cnt == m_size - AddrWidth'(1);
    assign n_last      = n_cnt == n_size - AddrWidth'(1);
    assign n_tick      = k_last && (order == ORDER_MNK || m_last);
    assign m_tick      = k_last && (order == ORDER_NMK || n_last);
    assign in_ready_o  = state == ST_BUSY && !(k_last && outstanding == OW'(OutDepth));
    assign fire        = in_valid_i && in_ready_o;
    assign push        = fire && k_last;
    assign pop         = out_valid_o && out_ready_i;
    assign init_save_o = fire && k_cnt == '0;
    assign out_nxt     = outstanding + OW'(push) - OW'(pop);
    assign size_ok     = |M_size_i && |K_size_i && |N_size_i;
    assign M_count_o   = m_cnt;
    assign K_count_o   = k_cnt;
    assign N_count_o   = n_cnt;
    assign busy_o      = state == ST_BUSY || state == ST_DRAIN;
    assign done_o      = state == ST_DONE;
    assign err_o       = err;
    assign out_m_o     = head.m;
    assign out_n_o     = head.n;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            order       <= ORDER_MNK;
            m_size      <= '0;
            k_size      <= '0;
            n_size      <= '0;
            m_cnt       <= '0;
            k_cnt       <= '0;
            n_cnt       <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            outstanding <= out_nxt;
            case (state)
                ST_IDLE: if (start_i) begin
                    err   <= !size_ok;
                    state <= size_ok ? ST_BUSY : ST_DONE;
                    if (size_ok) begin
                        order  <= loop_order_e'(loop_order_i);
                        m_size <= M_size_i;
                        k_size <= K_size_i;
                        n_size <= N_size_i;
                        m_cnt  <= '0;
                        k_cnt  <= '0;
                        n_cnt  <= '0;
                    end
                end
                ST_BUSY: if (fire) begin
                    k_cnt <= k_last ? '0 : k_cnt + AddrWidth'(1);
                    if (n_tick) n_cnt <= n_last ? '0 : n_cnt + AddrWidth'(1);
                    if (m_tick) m_cnt <= m_last ? '0 : m_cnt + AddrWidth'(1);
                    if (k_last && m_last && n_last) state <= ST_DRAIN;
                end
                // outstanding covers both the delay line and the buffer
                ST_DRAIN: if (out_nxt == '0) state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // stage 0 captures the token at the fire edge; PipeLatency further stages model the MAC
    always_ff @(posedge clk_i) begin
        if (rst_i) pipe_v <= '0;
        else pipe_v <= {pipe_v[PipeLatency-1:0], push};
    end

    always_ff @(posedge clk_i) begin
        pipe_d[0] <= '{m: m_cnt, n: n_cnt};
        for (int i = 1; i <= PipeLatency; i++) pipe_d[i] <= pipe_d[i-1];
    end

    gemm_result_fifo #(.Depth(OutDepth)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (pipe_v[PipeLatency]),
        .wdata (pipe_d[PipeLatency]),
        .pop   (pop),
        .valid (out_valid_o),
        .rdata (head)
    );
endmodule

// File: tb/tb_gemm_tile_controller.sv
// tb_gemm_tile_controller: randomized self-checking bench against a nested-loop
// reference of the beat sequence and a descriptor scoreboard.
module tb_gemm_tile_controller;
    import gemm_ctrl_pkg::*;

    localparam int PL = 2;
    localparam int OD = 4;

    logic        clk = 1'b0;
    logic        rst, start, order, in_valid, out_ready;
    logic [15:0] m_size, k_size, n_size;
    logic        in_ready, init_save, out_valid, busy, done, err;
    logic [15:0] m_count, k_count, n_count, out_m, out_n;

    int checks = 0;
    int failures = 0;
    int q_m[$], q_k[$], q_n[$], d_m[$], d_n[$];
    int fires, pops, tokens, dones, fire_cyc, ov_cyc, done_cyc;

    always #5 clk = ~clk;

    gemm_tile_controller #(.PipeLatency(PL), .OutDepth(OD)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .loop_order_i (order),
        .M_size_i     (m_size),
        .K_size_i     (k_size),
        .N_size_i     (n_size),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .M_count_o    (m_count),
        .K_count_o    (k_count),
        .N_count_o    (n_count),
        .init_save_o  (init_save),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_m_o      (out_m),
        .out_n_o      (out_n),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int mm, input int kk, input int nn, input bit ord,
                           input int pv, input int pr, input int hold, input bit inject);
        int exp_hold;
        q_m.delete(); q_k.delete(); q_n.delete(); d_m.delete(); d_n.delete();
        for (int a = 0; a < (ord ? nn : mm); a++)
            for (int b = 0; b < (ord ? mm : nn); b++)
                for (int k = 0; k < kk; k++) begin
                    q_m.push_back(ord ? b : a);
                    q_n.push_back(ord ? a : b);
                    q_k.push_back(k);
                    if (k == kk - 1) begin
                        d_m.push_back(ord ? b : a);
                        d_n.push_back(ord ? a : b);
                    end
                end
        exp_hold = (mm * kk * nn < OD * kk + kk - 1) ? mm * kk * nn : OD * kk + kk - 1;
        fires = 0; pops = 0; tokens = 0; dones = 0;
        fire_cyc = -1; ov_cyc = -1; done_cyc = -1;
        m_size = 16'(mm); k_size = 16'(kk); n_size = 16'(nn); order = ord;
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step();
        for (int c = 0; c < 3000 && dones == 0; c++) begin
            in_valid  = $urandom_range(99) < pv;
            out_ready = c >= hold && $urandom_range(99) < pr;
            start     = inject && busy && $urandom_range(7) == 0;
            if (start) begin
                m_size = 16'($urandom_range(7, 1));
                k_size = 16'($urandom_range(7, 1));
                n_size = 16'($urandom_range(7, 1));
                order  = 1'($urandom);
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                fires++;
                if (fire_cyc < 0) fire_cyc = c;
                if (q_m.size() == 0) check("extra_fire", 1, 0);
                else begin
                    check("m_count", m_count, q_m[0]);
                    check("k_count", k_count, q_k[0]);
                    check("n_count", n_count, q_n[0]);
                    check("init_save", init_save, q_k[0] == 0);
                    if (q_k[0] == kk - 1) tokens++;
                    void'(q_m.pop_front()); void'(q_k.pop_front()); void'(q_n.pop_front());
                end
            end else check("init_nofire", init_save, 0);
            if (out_valid) begin
                if (ov_cyc < 0) ov_cyc = c;
                if (out_ready) begin
                    pops++;
                    if (d_m.size() == 0) check("extra_desc", 1, 0);
                    else begin
                        check("out_m", out_m, d_m.pop_front());
                        check("out_n", out_n, d_n.pop_front());
                    end
                end
            end
            check("outstanding_bound", (tokens - pops) <= OD, 1);
            if (hold > 0 && c == hold - 1) begin
                check("hold_fires", fires, exp_hold);
                check("hold_stall", in_ready, 0);
            end
            if (done) begin
                dones++;
                done_cyc = c;
            end
            if (dones == 0) step();
        end
        check("done_seen", dones, 1);
        check("beats_left", q_m.size(), 0);
        check("descs_left", d_m.size(), 0);
        check("fires_total", fires, mm * kk * nn);
        check("descs_total", pops, mm * nn);
        check("err_clear", err, 0);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step();
        @(negedge clk);
        check("done_pulse_end", done, 0);
        check("idle_after", busy, 0);
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; order = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        m_size = '0; k_size = '0; n_size = '0;
        repeat (3) step();
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_init_save", init_save, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_counts", {m_count, k_count, n_count, out_m, out_n}, 0);
        step();
        rst = 1'b0;
        step();

        run_job(2, 3, 2, 1'b0, 100, 100, 0, 1'b0);
        run_job(2, 3, 2, 1'b1, 100, 100, 0, 1'b0);
        run_job(1, 1, 8, 1'b0, 100, 100, 10, 1'b0);

        m_size = 16'd2; k_size = 16'd2; n_size = 16'd0; start = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_err", err, 1);
        check("zero_no_issue", in_ready, 0);
        step();
        @(negedge clk);
        check("zero_done_once", done, 0);
        check("zero_err_sticky", err, 1);
        in_valid = 1'b0;
        step();
        run_job(1, 2, 1, 1'b0, 100, 100, 0, 1'b0);

        m_size = 16'd1; k_size = 16'd1; n_size = 16'd8; order = 1'b0; start = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        repeat (6) step();
        @(negedge clk);
        check("pre_rst_buffered", out_valid, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_counts", {m_count, k_count, n_count, out_m, out_n}, 0);
        step();
        run_job(1, 1, 1, 1'b0, 100, 100, 0, 1'b0);
        check("lat_out_valid", ov_cyc - fire_cyc, PL + 2);
        check("lat_done", done_cyc - fire_cyc, PL + 3);

        run_job(3, 4, 5, 1'b0, 60, 60, 0, 1'b1);
        run_job(3, 4, 5, 1'b1, 50, 40, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
